// File: rtl/drop_sequencer.sv
// Multi-cycle baggage-drop controller: fused height, 16-step non-restoring sqrt, registered decision/display.
// Optional macro DROP_ABORT_EN adds an abort input that returns any running sequence to IDLE silently.
module drop_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  sensor1,
   input  logic [7:0]  sensor2,
   input  logic [7:0]  sensor3,
   input  logic [7:0]  sensor4,
   input  logic [15:0] t_lim,
   input  logic        drop_en,
`ifdef DROP_ABORT_EN
   input  logic        abort,
`endif
   output logic        busy,
   output logic        done,
   output logic [15:0] t_act,
   output logic        drop_activated,
   output logic [6:0]  seven_seg1,
   output logic [6:0]  seven_seg2,
   output logic [6:0]  seven_seg3,
   output logic [6:0]  seven_seg4
);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_ROOT, S_DECIDE} state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD =
      (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         iter;
   logic [31:0]        rad;
   logic signed [17:0] rem;
   logic [15:0]        root;
   logic [15:0]        lim_q;
   logic               den_q;

   // Zero reading marks a faulty sensor; a faulty pair member drops the whole pair.
   function automatic logic [7:0] fuse(input logic [7:0] s1, s2, s3, s4);
      logic [9:0] sum;
      if (s1 == 8'd0 || s3 == 8'd0) begin
         sum = {2'b0, s2} + {2'b0, s4} + 10'd1;
         return sum[8:1];
      end else if (s2 == 8'd0 || s4 == 8'd0) begin
         sum = {2'b0, s1} + {2'b0, s3} + 10'd1;
         return sum[8:1];
      end else begin
         sum = {2'b0, s1} + {2'b0, s2} + {2'b0, s3} + {2'b0, s4} + 10'd2;
         return sum[9:2];
      end
   endfunction

   logic [7:0]         height;
   logic signed [17:0] rem_sh, rem_nx;
   logic [15:0]        root_nx;
   logic [15:0]        t_nx;

   always_comb begin
      height  = fuse(sensor1, sensor2, sensor3, sensor4);
      rem_sh  = {rem[15:0], rad[31:30]};
      // Non-restoring step: the sign of the running remainder picks add or subtract.
      if (rem[17])
         rem_nx = rem_sh + $signed({root, 2'b11});
      else
         rem_nx = rem_sh - $signed({root, 2'b01});
      root_nx = {root[14:0], ~rem_nx[17]};
      t_nx    = {1'b0, root[15:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         cnt            <= '0;
         iter           <= '0;
         rad            <= '0;
         rem            <= '0;
         root           <= '0;
         lim_q          <= '0;
         den_q          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         t_act          <= '0;
         drop_activated <= 1'b0;
         seven_seg1     <= '0;
         seven_seg2     <= '0;
         seven_seg3     <= '0;
         seven_seg4     <= '0;
      end else begin
         done <= 1'b0;
`ifdef DROP_ABORT_EN
         if (abort && state != S_IDLE) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else
`endif
         case (state)
            S_IDLE: if (start) begin
               busy <= 1'b1;
               cnt  <= CNT_LOAD;
               state <= (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt == '0) state <= S_SAMPLE;
               else           cnt   <= cnt - 1'b1;
            end
            S_SAMPLE: begin
               rad   <= {height, 24'd0} >> 8;
               rem   <= '0;
               root  <= '0;
               iter  <= '0;
               lim_q <= t_lim;
               den_q <= drop_en;
               state <= S_ROOT;
            end
            S_ROOT: begin
               rad  <= {rad[29:0], 2'b00};
               rem  <= rem_nx;
               root <= root_nx;
               iter <= iter + 1'b1;
               if (iter == 4'd15) state <= S_DECIDE;
            end
            S_DECIDE: begin
               t_act <= t_nx;
               if (!den_q) begin
                  {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <=
                     {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110};
                  drop_activated <= 1'b0;
               end else if (t_nx < lim_q) begin
                  {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <=
                     {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011};
                  drop_activated <= 1'b1;
               end else if (t_nx > lim_q) begin
                  {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <=
                     {7'b0000000, 7'b1110110, 7'b1011100, 7'b1111000};
                  drop_activated <= 1'b0;
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_drop_sequencer.sv
// Self-checking bench for drop_sequencer: directed cases plus random runs against a reference model.
module tb_drop_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  sensor1, sensor2, sensor3, sensor4;
   logic [15:0] t_lim;
   logic        drop_en;
   logic        abort;
   logic        busy, done, drop_activated;
   logic [15:0] t_act;
   logic [6:0]  seven_seg1, seven_seg2, seven_seg3, seven_seg4;

   int checks = 0;
   int errors = 0;

   localparam int LAT = 21;

   // Model-held expected output state
   logic [15:0] m_tact;
   logic        m_drop;
   logic [27:0] m_seg;

   always #5 clk = ~clk;

   drop_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3), .sensor4(sensor4),
      .t_lim(t_lim), .drop_en(drop_en),
`ifdef DROP_ABORT_EN
      .abort(abort),
`endif
      .busy(busy), .done(done), .t_act(t_act), .drop_activated(drop_activated),
      .seven_seg1(seven_seg1), .seven_seg2(seven_seg2),
      .seven_seg3(seven_seg3), .seven_seg4(seven_seg4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_height(input int a, b, c, d);
      if (a == 0 || c == 0) return (b + d + 1) / 2;
      if (b == 0 || d == 0) return (a + c + 1) / 2;
      return (a + b + c + d + 2) / 4;
   endfunction

   function automatic int isqrt(input int n);
      int q = 0;
      while ((q + 1) * (q + 1) <= n) q++;
      return q;
   endfunction

   function automatic int model_tact(input int a, b, c, d);
      return isqrt(model_height(a, b, c, d) * 65536) / 2;
   endfunction

   task automatic model_decide(input int ta, input int lim, input bit den);
      m_tact = 16'(ta);
      if (!den) begin
         m_seg = {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110}; m_drop = 1'b0;
      end else if (ta < lim) begin
         m_seg = {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011}; m_drop = 1'b1;
      end else if (ta > lim) begin
         m_seg = {7'b0000000, 7'b1110110, 7'b1011100, 7'b1111000}; m_drop = 1'b0;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_tact"}, 32'(t_act), 32'(m_tact));
      chk({tag, "_drop"}, 32'(drop_activated), 32'(m_drop));
      chk({tag, "_seg"}, 32'({seven_seg1, seven_seg2, seven_seg3, seven_seg4}), 32'(m_seg));
   endtask

   task automatic quiet_cycles(input string tag, input int n);
      int pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk({tag, "_nodone"}, 32'(pulses), 32'd0);
   endtask

   // One full request; inputs are scrambled mid-run to prove they were latched in SAMPLE.
   task automatic run(input string tag, input int a, b, c, d, input int lim,
                      input bit den, input bit repulse);
      int n = 0;
      bit got = 0;
      model_decide(model_tact(a, b, c, d), lim, den);
      @(negedge clk);
      sensor1 = 8'(a); sensor2 = 8'(b); sensor3 = 8'(c); sensor4 = 8'(d);
      t_lim = 16'(lim); drop_en = den; start = 1'b1;
      while (!got && n < 60) begin
         @(posedge clk); #1; n++;
         if (n == 1) begin
            chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
            if (!repulse) start = 1'b0;
         end
         if (n == 6) begin
            sensor1 = 8'($urandom); sensor2 = 8'($urandom);
            sensor3 = 8'($urandom); sensor4 = 8'($urandom);
            t_lim = 16'($urandom); drop_en = ~drop_en;
         end
         if (n == 10) start = 1'b0;
         if (done) got = 1;
      end
      chk({tag, "_latency"}, 32'(n), 32'(LAT));
      chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
      check_outputs(tag);
      @(posedge clk); #1;
      chk({tag, "_pulse_width"}, 32'(done), 32'd0);
      if (repulse) quiet_cycles(tag, 25);
   endtask

   initial begin
      int a, b, c, d, ta, lim;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      sensor1 = '0; sensor2 = '0; sensor3 = '0; sensor4 = '0;
      t_lim = '0; drop_en = 1'b0;
      m_tact = '0; m_drop = 1'b0; m_seg = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      check_outputs("reset");
      @(negedge clk); rst_n = 1'b1;

      // Equal compare straight after reset keeps blank display.
      run("equal", 16, 16, 16, 16, 16'h0200, 1'b1, 1'b0);
      run("drop16", 16, 16, 16, 16, 16'h0201, 1'b1, 1'b0);
      run("hot16", 16, 16, 16, 16, 16'h01FF, 1'b1, 1'b0);
      run("s1zero", 0, 100, 50, 101, 2000, 1'b1, 1'b0);
      chk("s1zero_val", 32'(t_act), 32'd1286);
      run("s2zero", 40, 0, 41, 9, 2000, 1'b1, 1'b0);
      chk("s2zero_val", 32'(t_act), 32'd819);
      run("cold_max", 255, 255, 255, 255, 16'hFFFF, 1'b0, 1'b0);
      chk("cold_max_val", 32'(t_act), 32'd2043);
      run("repulse", 200, 30, 7, 99, 1000, 1'b1, 1'b1);

      // Reset in the middle of ROOT.
      @(negedge clk);
      sensor1 = 8'd16; sensor2 = 8'd16; sensor3 = 8'd16; sensor4 = 8'd16;
      t_lim = 16'h0300; drop_en = 1'b1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      m_tact = '0; m_drop = 1'b0; m_seg = '0;
      chk("midrst_busy", 32'(busy), 32'd0);
      check_outputs("midrst");
      @(negedge clk); rst_n = 1'b1;
      quiet_cycles("midrst", 30);
      run("after_rst", 77, 88, 99, 66, 3000, 1'b1, 1'b0);

      for (int i = 0; i < 10; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
         b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
         c = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
         d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
         ta = model_tact(a, b, c, d);
         case ($urandom_range(0, 3))
            0: lim = ta;
            1: lim = ta + int'($urandom_range(1, 40));
            2: lim = (ta > 40) ? ta - int'($urandom_range(1, 40)) : 0;
            default: lim = int'($urandom_range(0, 65535));
         endcase
         run($sformatf("rand%0d", i), a, b, c, d, lim, 1'($urandom_range(0, 4) != 0), 1'b0);
      end

`ifdef DROP_ABORT_EN
      run("pre_abort", 16, 16, 16, 16, 16'h01FF, 1'b1, 1'b0);
      @(negedge clk);
      sensor1 = 8'd200; sensor2 = 8'd200; sensor3 = 8'd200; sensor4 = 8'd200;
      t_lim = 16'hFFFF; drop_en = 1'b1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      quiet_cycles("abort", 25);
      check_outputs("abort");
      run("post_abort", 50, 60, 70, 80, 100, 1'b1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/drop_sequencer.md
Name: drop_sequencer

Overview:
- Multi-cycle controller for the baggage-drop datapath.
- Per request, it samples the four height sensors and forms the fused height with the zero-sensor fallback rule.
- It then runs a non-restoring square root, one result bit per clock, compares the derived fall time against the limit, and registers the drop decision and the four-digit display code.
- It replaces the single-cycle combinational path, which is not timing-closable, and sits between the sensor front end and the display/actuator drivers.

Parameters:
- SETTLE_CYCLES, 2, idle cycles after start before sensors are sampled (0 = sample immediately)
- CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a measurement; accepted only in IDLE
- sensor1..sensor4  input  8 each  height sensor readings; 0 = sensor faulty
- t_lim  input  16  time limit, Q8.8, same units as t_act
- drop_en  input  1  drop enable
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; decision outputs updated on the same edge
- t_act  output  16  computed fall time, Q8.8
- drop_activated  output  1  drop command
- seven_seg1..seven_seg4  output  7 each  display segments

Behaviour:
- Reset (asynchronous, any state): state = IDLE; busy, done, drop_activated, t_act, all seven_seg = 0 (blank); counters and datapath registers cleared. No done pulse follows an interrupted run.
- States: IDLE, SETTLE, SAMPLE, ROOT, DECIDE.
- IDLE:
  - start=1 -> SETTLE with counter loaded, or directly to SAMPLE when SETTLE_CYCLES=0.
  - start is accepted in the same cycle that done is high.
- SETTLE: stays exactly SETTLE_CYCLES cycles, then -> SAMPLE. start is ignored in all non-IDLE states.
- SAMPLE (1 cycle):
  - Registers sensors, t_lim and drop_en. Later input changes do not affect the run.
  - Height, using 10-bit intermediate sums and an 8-bit result:
    - if s1==0 or s3==0: (s2+s4+1)>>1
    - else if s2==0 or s4==0: (s1+s3+1)>>1
    - else: (s1+s2+s3+s4+2)>>2
  - Loads radicand = height<<16 (32 bits); clears remainder and root.
- ROOT (exactly 16 cycles):
  - Each cycle brings down 2 radicand bits MSB-first and performs a non-restoring step: add if the remainder is negative, else subtract.
  - Each cycle shifts one root bit in.
  - The remainder register is 18 bits signed; no truncation is allowed.
  - Result Q = floor(256*sqrt(height)), maximum 4087.
- DECIDE (1 cycle): t_act_next = Q>>1. Priority:
  - drop_en==0 -> COLD: seg1..4 = 0111001,1011100,0111000,1011110; drop_activated=0
  - t_act_next < t_lim -> DROP: 1011110,1010000,1011100,1110011; drop_activated=1
  - t_act_next > t_lim -> HOT: 0000000,1110110,1011100,1111000; drop_activated=0
  - equal -> display and drop_activated keep their previous values; t_act still updates.
  - -> IDLE; done=1 for exactly one cycle.
- Outputs are registered and change only on the DECIDE->IDLE edge or on reset.
- Latency: with the start-accepting edge counted as edge 1, done is high after edge SETTLE_CYCLES+19 (edge 21 at default). busy rises after edge 1 and falls together with done rising.

Optional Feature:
- Macro DROP_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 in any non-IDLE state -> IDLE on the next edge. No done pulse; t_act, display and drop_activated are unchanged.
  - abort in IDLE has no effect. abort beats a simultaneous DECIDE completion.
- Undefined: port absent; every accepted run completes.

Test Plan:
- s1..s4 = 16, drop_en=1, t_lim=0x0201 -> height 16, Q=1024, t_act=0x0200, DROP codes, drop_activated=1, done pulse after edge 21. Repeat with t_lim=0x01FF -> HOT, drop_activated=0.
- s1=0, s2=100, s3=50, s4=101, t_lim=2000 -> height 101, t_act=1286, DROP. Then s1=40, s2=0, s3=41, s4=9 -> height 41, t_act=819.
- All sensors = 255, t_lim=0xFFFF, drop_en=0 -> height 255, t_act=2043, COLD codes, drop_activated=0.
- Straight after reset, sensors = 16, t_lim=0x0200 (equal) -> done pulses, t_act=0x0200, segments stay 0, drop_activated stays 0.
- start re-pulsed while busy -> ignored; exactly one done. rst_n low during ROOT -> all outputs 0 immediately, no done afterwards, and the next start runs normally.
- With DROP_ABORT_EN: abort in cycle 8 of ROOT after a prior HOT result -> IDLE next edge, no done, HOT outputs retained.
